// File: rtl/mem_stage.sv
// Memory-access pipeline stage: byte/half/word loads and stores into a word-addressed
// data memory with registered MEM/WB outputs. Memory has no reset; its zero power-up value comes from configuration.
module mem_stage #(
  parameter int NB_REG      = 32,
  parameter int NB_ADDR     = 5,
  parameter int NB_MEM_ADDR = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_halt,
  input  logic                   i_mem_read_CU,
  input  logic                   i_mem_write_CU,
  input  logic                   i_mem_to_reg_CU,
  input  logic                   i_reg_write_CU,
  input  logic [1:0]             i_width_CU,
  input  logic                   i_unsigned_CU,
  input  logic [NB_REG-1:0]      i_alu_result,
  input  logic [NB_REG-1:0]      i_write_data,
  input  logic [NB_ADDR-1:0]     i_rd_from_EX,
  input  logic [NB_MEM_ADDR-1:0] i_debug_addr,
  output logic [NB_REG-1:0]      o_debug_data,
  output logic [NB_REG-1:0]      o_read_data,
  output logic [NB_REG-1:0]      o_alu_result,
  output logic [NB_ADDR-1:0]     o_rd_to_WB,
  output logic                   o_reg_write,
  output logic                   o_mem_to_reg,
  output logic                   o_misaligned
);

  localparam int DEPTH = 2 ** NB_MEM_ADDR;
  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b11;

  logic [NB_REG-1:0]      mem_q [DEPTH];
  logic [NB_MEM_ADDR-1:0] idx_s;
  logic [1:0]             lane_s;
  logic                   access_s;
  logic                   misaligned_s;
  logic                   we_s;
  logic [NB_REG-1:0]      rd_word_s;
  logic [NB_REG-1:0]      wr_word_s;
  logic [NB_REG-1:0]      load_s;
  logic [7:0]             byte_s;
  logic [15:0]            half_s;

  logic [NB_REG-1:0]  read_data_d, read_data_q;
  logic [NB_REG-1:0]  alu_result_d, alu_result_q;
  logic [NB_ADDR-1:0] rd_d, rd_q;
  logic               reg_write_d, reg_write_q;
  logic               mem_to_reg_d, mem_to_reg_q;
  logic               misaligned_d, misaligned_q;

  // Upper address bits beyond the memory depth are dropped, so addresses wrap.
  assign idx_s        = i_alu_result[NB_MEM_ADDR+1:2];
  assign lane_s       = i_alu_result[1:0];
  assign rd_word_s    = mem_q[idx_s];
  assign o_debug_data = mem_q[i_debug_addr];
  assign access_s     = i_mem_read_CU | i_mem_write_CU;
  assign byte_s       = rd_word_s[{lane_s, 3'b000} +: 8];
  assign half_s       = rd_word_s[{lane_s[1], 4'b0000} +: 16];

  // Alignment check; only a real memory access can be misaligned.
  always_comb begin
    misaligned_s = 1'b0;
    case (i_width_CU)
      W_BYTE:  misaligned_s = 1'b0;
      W_HALF:  misaligned_s = access_s & lane_s[0];
      W_WORD:  misaligned_s = access_s & (lane_s != 2'b00);
      default: misaligned_s = access_s;
    endcase
  end

  assign we_s = i_mem_write_CU & ~i_halt & ~misaligned_s;

  // Merge the store lanes into the current word (read-modify-write).
  always_comb begin
    wr_word_s = rd_word_s;
    case (i_width_CU)
      W_BYTE:  wr_word_s[{lane_s, 3'b000} +: 8] = i_write_data[7:0];
      W_HALF:  wr_word_s[{lane_s[1], 4'b0000} +: 16] = i_write_data[15:0];
      default: wr_word_s = i_write_data;
    endcase
  end

  // Lane extraction and extension; a simultaneous store wins over the load.
  always_comb begin
    load_s = '0;
    if (!i_mem_read_CU || i_mem_write_CU || misaligned_s) begin
      load_s = '0;
    end else begin
      case (i_width_CU)
        W_BYTE:  load_s = {{(NB_REG-8){~i_unsigned_CU & byte_s[7]}}, byte_s};
        W_HALF:  load_s = {{(NB_REG-16){~i_unsigned_CU & half_s[15]}}, half_s};
        W_WORD:  load_s = rd_word_s;
        default: load_s = '0;
      endcase
    end
  end

  // Next-state values for the MEM/WB register.
  always_comb begin
    read_data_d  = load_s;
    alu_result_d = i_alu_result;
    rd_d         = i_rd_from_EX;
    reg_write_d  = i_reg_write_CU & ~misaligned_s;
    mem_to_reg_d = i_mem_to_reg_CU;
    misaligned_d = misaligned_s;
  end

  // MEM/WB pipeline register with stall hold.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      read_data_q  <= '0;
      alu_result_q <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      misaligned_q <= 1'b0;
    end else if (!i_halt) begin
      read_data_q  <= read_data_d;
      alu_result_q <= alu_result_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Data memory write port; reset suppresses the write but never clears contents.
  always_ff @(posedge i_clk) begin
    if (we_s && !i_reset) begin
      mem_q[idx_s] <= wr_word_s;
    end
  end

  assign o_read_data  = read_data_q;
  assign o_alu_result = alu_result_q;
  assign o_rd_to_WB   = rd_q;
  assign o_reg_write  = reg_write_q;
  assign o_mem_to_reg = mem_to_reg_q;
  assign o_misaligned = misaligned_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic
// checked against an arithmetic reference model of the memory stage.
module tb_mem_stage;

  logic        i_clk = 1'b0;
  logic        i_reset, i_halt, i_mem_read_CU, i_mem_write_CU;
  logic        i_mem_to_reg_CU, i_reg_write_CU, i_unsigned_CU;
  logic [1:0]  i_width_CU;
  logic [31:0] i_alu_result, i_write_data;
  logic [4:0]  i_rd_from_EX;
  logic [7:0]  i_debug_addr;
  logic [31:0] o_debug_data, o_read_data, o_alu_result;
  logic [4:0]  o_rd_to_WB;
  logic        o_reg_write, o_mem_to_reg, o_misaligned;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_m [256];
  logic [31:0] exp_read, exp_alu;
  logic [4:0]  exp_rd;
  logic        exp_rw, exp_m2r, exp_mis;

  always #5 i_clk = ~i_clk;

  mem_stage dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_halt(i_halt),
    .i_mem_read_CU(i_mem_read_CU), .i_mem_write_CU(i_mem_write_CU),
    .i_mem_to_reg_CU(i_mem_to_reg_CU), .i_reg_write_CU(i_reg_write_CU),
    .i_width_CU(i_width_CU), .i_unsigned_CU(i_unsigned_CU),
    .i_alu_result(i_alu_result), .i_write_data(i_write_data),
    .i_rd_from_EX(i_rd_from_EX), .i_debug_addr(i_debug_addr),
    .o_debug_data(o_debug_data), .o_read_data(o_read_data),
    .o_alu_result(o_alu_result), .o_rd_to_WB(o_rd_to_WB),
    .o_reg_write(o_reg_write), .o_mem_to_reg(o_mem_to_reg),
    .o_misaligned(o_misaligned)
  );

  // Drive one request, predict the outputs from the access rules, clock it in.
  task automatic apply(input logic rd, input logic wr, input logic rw, input logic [1:0] w,
                       input logic uns, input logic [31:0] addr, input logic [31:0] data,
                       input logic halt);
    logic [7:0]  idx;
    logic [31:0] lane, sh, word, part, newv;
    logic        mis;
    logic [4:0]  rdst;
    rdst = 5'($urandom);
    i_mem_read_CU = rd; i_mem_write_CU = wr; i_reg_write_CU = rw; i_mem_to_reg_CU = rd;
    i_width_CU = w; i_unsigned_CU = uns; i_alu_result = addr; i_write_data = data;
    i_rd_from_EX = rdst; i_halt = halt;
    idx  = 8'((addr / 32'd4) % 32'd256);
    lane = addr % 32'd4;
    sh   = lane * 32'd8;
    mis  = (rd || wr) && ((w == 2'd1 && (addr % 32'd2) == 32'd1) ||
                          (w == 2'd3 && lane != 32'd0) || w == 2'd2);
    word = mem_m[idx];
    newv = word;
    if (!halt) begin
      exp_alu = addr; exp_rd = rdst; exp_m2r = rd; exp_rw = rw && !mis; exp_mis = mis;
      if (!rd || wr || mis) exp_read = 32'd0;
      else if (w == 2'd3) exp_read = word;
      else if (w == 2'd0) begin
        part = (word >> sh) & 32'hFF;
        exp_read = (!uns && part >= 32'h80) ? part + 32'hFFFF_FF00 : part;
      end else begin
        part = (word >> sh) & 32'hFFFF;
        exp_read = (!uns && part >= 32'h8000) ? part + 32'hFFFF_0000 : part;
      end
      if (wr && !mis) begin
        if (w == 2'd3) newv = data;
        else if (w == 2'd0) newv = (word & ~(32'hFF << sh)) | ((data & 32'hFF) << sh);
        else newv = (word & ~(32'hFFFF << sh)) | ((data & 32'hFFFF) << sh);
      end
    end
    @(posedge i_clk); #1;
    if (!halt && wr && !mis) mem_m[idx] = newv;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({o_read_data, o_alu_result, o_rd_to_WB, o_reg_write, o_mem_to_reg, o_misaligned} !== 72'd0) begin
      bad++; $display("FAIL reset_outputs: got %h %h %h %b%b%b want all zero",
                      o_read_data, o_alu_result, o_rd_to_WB, o_reg_write, o_mem_to_reg, o_misaligned);
    end
    @(negedge i_clk); i_reset = 1'b0;
  endtask

  task automatic init_memory();
    for (int i = 0; i < 16; i++) apply(1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 32'(i * 4), 32'd0, 1'b0);
  endtask

  task automatic test_word();
    apply(1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);
    apply(1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 32'h10, 32'd0, 1'b0);
    total++;
    if (o_read_data !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL word_load: got %h want deadbeef", o_read_data);
    end
    i_debug_addr = 8'd4; #1;
    total++;
    if (o_debug_data !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL word_debug: got %h want deadbeef", o_debug_data);
    end
  endtask

  task automatic test_byte();
    apply(1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 32'h10, 32'h1122_3344, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0000_00AA, 1'b0);
    i_debug_addr = 8'd4; #1;
    total++;
    if (o_debug_data !== 32'hAA22_3344) begin
      bad++; $display("FAIL byte_store: got %h want aa223344", o_debug_data);
    end
    apply(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 32'h13, 32'd0, 1'b0);
    total++;
    if (o_read_data !== 32'hFFFF_FFAA) begin
      bad++; $display("FAIL byte_signed: got %h want ffffffaa", o_read_data);
    end
    apply(1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 32'h13, 32'd0, 1'b0);
    total++;
    if (o_read_data !== 32'h0000_00AA) begin
      bad++; $display("FAIL byte_unsigned: got %h want 000000aa", o_read_data);
    end
  endtask

  task automatic test_misaligned();
    apply(1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 32'h11, 32'd0, 1'b0);
    total++;
    if ({o_misaligned, o_reg_write, o_read_data} !== {1'b1, 1'b0, 32'd0}) begin
      bad++; $display("FAIL half_misaligned: got mis=%b rw=%b rd=%h want 1 0 0",
                      o_misaligned, o_reg_write, o_read_data);
    end
    apply(1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 32'h12, 32'h5555_5555, 1'b0);
    i_debug_addr = 8'd4; #1;
    total++;
    if (o_debug_data !== 32'hAA22_3344 || o_misaligned !== 1'b1) begin
      bad++; $display("FAIL word_store_misaligned: got %h mis=%b want aa223344 1", o_debug_data, o_misaligned);
    end
    apply(1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 32'h10, 32'd0, 1'b0);
    total++;
    if (o_misaligned !== 1'b0 || o_reg_write !== 1'b1 || o_read_data !== 32'h44) begin
      bad++; $display("FAIL aligned_after_mis: got mis=%b rw=%b rd=%h want 0 1 44",
                      o_misaligned, o_reg_write, o_read_data);
    end
  endtask

  task automatic test_halt();
    apply(1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 32'h20, 32'hCAFE_F00D, 1'b1);
    i_debug_addr = 8'd8; #1;
    total++;
    if (o_debug_data !== 32'd0 || o_alu_result !== 32'h10 || o_read_data !== 32'h44) begin
      bad++; $display("FAIL halt_hold: got mem=%h alu=%h rd=%h want 0 10 44", o_debug_data, o_alu_result, o_read_data);
    end
    apply(1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 32'h20, 32'hCAFE_F00D, 1'b0);
    total++;
    if (o_debug_data !== 32'hCAFE_F00D || o_alu_result !== 32'h20) begin
      bad++; $display("FAIL halt_release: got mem=%h alu=%h want cafef00d 20", o_debug_data, o_alu_result);
    end
  endtask

  task automatic test_wrap();
    apply(1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 32'h410, 32'd0, 1'b0);
    total++;
    if (o_read_data !== 32'hAA22_3344) begin
      bad++; $display("FAIL wrap_load: got %h want aa223344", o_read_data);
    end
    apply(1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 32'hFFFF_FC14, 32'h600D_F00D, 1'b0);
    i_debug_addr = 8'd5; #1;
    total++;
    if (o_debug_data !== 32'h600D_F00D) begin
      bad++; $display("FAIL wrap_store: got %h want 600df00d", o_debug_data);
    end
  endtask

  task automatic test_back_to_back();
    apply(1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 32'h2A, 32'h1234_8001, 1'b0);
    apply(1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 32'h2A, 32'd0, 1'b0);
    total++;
    if (o_read_data !== 32'hFFFF_8001) begin
      bad++; $display("FAIL half_signed_b2b: got %h want ffff8001", o_read_data);
    end
    apply(1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 32'h28, 32'h0000_7FFF, 1'b0);
    apply(1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 32'h2A, 32'd0, 1'b0);
    total++;
    if (o_read_data !== 32'h0000_8001) begin
      bad++; $display("FAIL half_unsigned: got %h want 00008001", o_read_data);
    end
    apply(1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 32'h28, 32'd0, 1'b0);
    total++;
    if (o_read_data !== 32'h8001_7FFF) begin
      bad++; $display("FAIL word_after_halves: got %h want 80017fff", o_read_data);
    end
    apply(1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 32'h28, 32'h0BAD_CAFE, 1'b0);
    total++;
    if (o_read_data !== 32'd0 || mem_m[10] !== 32'h0BAD_CAFE) begin
      bad++; $display("FAIL store_priority: got %h want 0", o_read_data);
    end
  endtask

  task automatic test_async_reset();
    apply(1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 32'h10, 32'd0, 1'b0);
    i_mem_read_CU = 1'b0; i_mem_write_CU = 1'b1; i_width_CU = 2'd3; i_alu_result = 32'h10;
    i_write_data = 32'h1234_5678; i_halt = 1'b0;
    #2 i_reset = 1'b1; #1;
    total++;
    if ({o_read_data, o_alu_result, o_rd_to_WB, o_reg_write, o_mem_to_reg, o_misaligned} !== 72'd0) begin
      bad++; $display("FAIL async_reset: got %h %h %h %b%b%b want all zero",
                      o_read_data, o_alu_result, o_rd_to_WB, o_reg_write, o_mem_to_reg, o_misaligned);
    end
    @(posedge i_clk); #1;
    i_debug_addr = 8'd4; #1;
    total++;
    if (o_debug_data !== 32'hAA22_3344 || o_alu_result !== 32'd0) begin
      bad++; $display("FAIL reset_store_suppressed: got mem=%h alu=%h want aa223344 0", o_debug_data, o_alu_result);
    end
    #2 i_reset = 1'b0;
    exp_read = 32'd0; exp_alu = 32'd0; exp_rd = 5'd0; exp_rw = 1'b0; exp_m2r = 1'b0; exp_mis = 1'b0;
    apply(1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 32'h10, 32'd0, 1'b0);
    total++;
    if (o_read_data !== 32'hAA22_3344 || o_reg_write !== 1'b1) begin
      bad++; $display("FAIL post_reset_edge: got %h rw=%b want aa223344 1", o_read_data, o_reg_write);
    end
  endtask

  task automatic test_random();
    logic [7:0] dbg;
    for (int n = 0; n < 400; n++) begin
      apply(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
            $urandom & 32'h0000_0C3F, $urandom, $urandom_range(0, 7) == 0);
      total++;
      if (o_read_data !== exp_read || o_alu_result !== exp_alu || o_rd_to_WB !== exp_rd ||
          o_reg_write !== exp_rw || o_mem_to_reg !== exp_m2r || o_misaligned !== exp_mis) begin
        bad++; $display("FAIL random_outputs[%0d]: got %h %h %h %b%b%b want %h %h %h %b%b%b", n,
                        o_read_data, o_alu_result, o_rd_to_WB, o_reg_write, o_mem_to_reg, o_misaligned,
                        exp_read, exp_alu, exp_rd, exp_rw, exp_m2r, exp_mis);
      end
      dbg = 8'($urandom_range(0, 15));
      i_debug_addr = dbg; #1;
      total++;
      if (o_debug_data !== mem_m[dbg]) begin
        bad++; $display("FAIL random_memory[%0d]: word %0d got %h want %h", n, dbg, o_debug_data, mem_m[dbg]);
      end
    end
  endtask

  initial begin
    i_reset = 1'b1; i_halt = 1'b0; i_mem_read_CU = 1'b0; i_mem_write_CU = 1'b0;
    i_mem_to_reg_CU = 1'b0; i_reg_write_CU = 1'b0; i_width_CU = 2'd0; i_unsigned_CU = 1'b0;
    i_alu_result = 32'd0; i_write_data = 32'd0; i_rd_from_EX = 5'd0; i_debug_addr = 8'd0;
    for (int i = 0; i < 256; i++) mem_m[i] = 32'd0;
    exp_read = 32'd0; exp_alu = 32'd0; exp_rd = 5'd0; exp_rw = 1'b0; exp_m2r = 1'b0; exp_mis = 1'b0;
    test_reset();
    init_memory();
    test_word();
    test_byte();
    test_misaligned();
    test_halt();
    test_wrap();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
